seg_demux: RTL and testbench
============================

Name: seg_demux

Overview:
- Receive-side counterpart of the four-segment ROM sequencer.
- Accepts the sequenced 8-bit sample stream, tracks segment index and in-segment address with the same length table and skip rules as the transmitter, and writes each byte into one of four per-channel capture RAMs.
- Sits between the stream source (or loopback) and the four capture RAM write ports.

Parameters:
- DW, 8, data width
- AW, 8, RAM address width; must hold LEN0-1
- LEN0, 132, segment 0 length in bytes
- LEN1, 121, segment 1 length in bytes
- LEN2, 88, segment 2 length in bytes
- LEN3, 55, segment 3 length in bytes

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- enable  in  1  run when high; low forces resynchronise (IDLE)
- ch_en  in  4  channel enable mask; bit n = segment n present in stream
- in_valid  in  1  in_data carries a stream byte this cycle
- in_data  in  DW  stream byte
- wr_en  out  4  one-hot RAM write strobe, bit n = channel n
- wr_addr  out  AW  RAM write address (in-segment byte index)
- wr_data  out  DW  RAM write data
- seg_idx  out  2  segment currently being received
- seg_done  out  1  one-cycle pulse: segment completed
- frame_done  out  1  one-cycle pulse: sequence wrapped to a lower/equal index

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_en=0, wr_addr=0, wr_data=0, seg_idx=0, seg_done=0, frame_done=0.
  - Internal count=0, mask_q=0, state IDLE.
  - Reset has priority over everything, including mid-segment.
- States: IDLE, RUN.
- IDLE (enable=0):
  - count=0, no writes.
  - mask_q <= ch_en every cycle.
  - seg_idx <= lowest set bit of ch_en; 0 if ch_en=0.
  - enable=1 moves to RUN on the next edge; seg_idx is held.
- RUN, accepted byte (in_valid=1):
  - Registered outputs next cycle: wr_data=in_data, wr_addr=count.
  - wr_en = one-hot(seg_idx) if mask_q[seg_idx]=1, else 0. A disabled segment is counted but not stored; the transmitter sends zeros there.
  - Write latency is exactly 1 cycle from the accepted byte.
- RUN, in_valid=0: count and seg_idx hold; wr_en=0 next cycle; no pulses.
- Segment boundary (accepted byte with count == LEN[seg_idx]-1):
  - count <= 0; seg_done pulses next cycle.
  - mask_q <= ch_en (sampled at the boundary).
  - seg_idx <= first set bit of ch_en scanning circularly from seg_idx+1; if none is set, seg_idx is kept.
  - frame_done pulses together with seg_done when new seg_idx <= old seg_idx (wrap, or only one channel enabled).
- Non-boundary accepted byte: count <= count+1. Count never exceeds LEN[seg_idx]-1.
- enable falls mid-segment:
  - Next edge goes to IDLE, count=0, wr_en=0.
  - No seg_done/frame_done. Partial RAM contents remain.
- ch_en changes mid-segment: no effect until the next boundary or IDLE.
- ch_en=0 in RUN: segment 0 repeats, no writes, pulses still generated per LEN0.
- Arithmetic: count is AW bits, unsigned; length compare is against LENn-1 as AW-bit constants.

Decomposition:
- Package seg_pkg:
  - SEG_LEN constants 132/121/88/55.
  - seg index type (2-bit).
  - function next_seg(cur, mask) implementing the circular first-set-bit rule.
  - Shared with the transmitter so both ends agree on sequencing.
- Sub-module seg_next_sel: combinational rotate/priority pick, reused by the sequencer.
- Everything else lives in seg_demux.

Test Plan:
- Reset then enable=1, ch_en=4'b1111, continuous valid ramp data:
  - Writes go to ch0 at addr 0..131, ch1 0..120, ch2 0..87, ch3 0..54.
  - seg_done fires 4 times; frame_done fires once after ch3's last byte; then ch0 addr 0 follows.
- ch_en=4'b0101:
  - Sequence is seg 0 (132 bytes) -> seg 2 (88) -> seg 0.
  - frame_done pulses after seg 2; wr_en never 4'b0010/4'b1000.
- ch_en=4'b1000, enable rises:
  - seg_idx=3 from IDLE; 55-byte segments repeat.
  - seg_done and frame_done pulse every 55 accepted bytes.
- in_valid toggling 1/0 every cycle during seg 1:
  - Addresses 0..120 are contiguous with no gaps or duplicates.
  - The segment completes after 121 accepted bytes (242 cycles).
- enable dropped at seg 0 count=70, re-raised:
  - No pulses; restart writes ch0 at addr 0.
  - rst asserted at seg 2 count=40 gives all outputs 0 the next cycle.
- ch_en changed 4'b1111 -> 4'b0001 during seg 1:
  - seg 1 completes with all 121 writes.
  - Next segment is 0, with frame_done asserted.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared sequencing definitions for the four-segment ROM sequencer and its receiver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package seg_pkg;

    // Segment index: four segments, 2 bits.
    typedef logic [1:0] seg_idx_t;

    // Receiver sequencing state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Segment lengths in bytes. Both ends of the link must use the same table.
    localparam int SEG_LEN0 = 132;
    localparam int SEG_LEN1 = 121;
    localparam int SEG_LEN2 = 88;
    localparam int SEG_LEN3 = 55;

    // First set bit of mask, scanning circularly from cur+1. The scan covers
    // four positions, the last being cur itself, so a single enabled channel
    // selects itself again. With an empty mask cur is returned unchanged.
    function automatic seg_idx_t next_seg(input seg_idx_t cur, input logic [3:0] mask);
        seg_idx_t res;
        seg_idx_t cand;
        logic     hit;
        res = cur;
        hit = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = cur + seg_idx_t'(i);
            if (!hit && mask[cand]) begin
                res = cand;
                hit = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_next_sel.sv
// Combinational next-segment pick: rotate the channel mask past cur and take the first set bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
//
// Ports:
//   cur  - segment currently active
//   mask - channel enable mask, bit n = segment n present
//   nxt  - next segment to run (cur when mask is empty)
module seg_next_sel
    import seg_pkg::*;
(
    input  seg_idx_t   cur,
    input  logic [3:0] mask,
    output seg_idx_t   nxt
);

    always_comb begin
        nxt = next_seg(cur, mask);
    end

endmodule

// File: rtl/seg_demux.sv
// Receive-side segment demultiplexer: tracks segment/address of the sequenced byte stream and steers bytes to four capture RAMs.
// Latency: every accepted byte produces its RAM write exactly one cycle later; seg_done/frame_done line up with the last write.
// Backpressure: none; the source paces the stream with in_valid and every valid byte is consumed.
//
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   enable                - run when high; low drops to IDLE and resynchronises
//   ch_en                 - channel enable mask, sampled in IDLE and at segment boundaries
//   in_valid, in_data     - incoming stream byte
//   wr_en, wr_addr, wr_data - one-hot capture RAM write port
//   seg_idx               - segment currently being received
//   seg_done, frame_done  - one-cycle completion pulses
module seg_demux
    import seg_pkg::*;
#(
    parameter int DW   = 8,
    parameter int AW   = 8,
    parameter int LEN0 = SEG_LEN0,
    parameter int LEN1 = SEG_LEN1,
    parameter int LEN2 = SEG_LEN2,
    parameter int LEN3 = SEG_LEN3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [3:0]    ch_en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic [3:0]    wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [1:0]    seg_idx,
    output logic          seg_done,
    output logic          frame_done
);

    // Last in-segment address of each segment, as an AW-bit constant.
    function automatic logic [AW-1:0] last_addr(input seg_idx_t s);
        logic [AW-1:0] res;
        case (s)
            2'd0:    res = AW'(LEN0 - 1);
            2'd1:    res = AW'(LEN1 - 1);
            2'd2:    res = AW'(LEN2 - 1);
            default: res = AW'(LEN3 - 1);
        endcase
        return res;
    endfunction

    state_t        state_q,      state_d;
    logic [AW-1:0] count_q,      count_d;
    logic [3:0]    mask_q,       mask_d;
    seg_idx_t      seg_q,        seg_d;
    logic [3:0]    wr_en_q,      wr_en_d;
    logic [AW-1:0] wr_addr_q,    wr_addr_d;
    logic [DW-1:0] wr_data_q,    wr_data_d;
    logic          seg_done_q,   seg_done_d;
    logic          frame_done_q, frame_done_d;

    seg_idx_t      first_seg;
    seg_idx_t      bnd_seg;

    // Lowest set bit of ch_en: a circular scan starting after segment 3
    // begins at segment 0.
    seg_next_sel u_first_sel (
        .cur  (2'd3),
        .mask (ch_en),
        .nxt  (first_seg)
    );

    // Segment that follows the current one at a boundary.
    seg_next_sel u_bnd_sel (
        .cur  (seg_q),
        .mask (ch_en),
        .nxt  (bnd_seg)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        mask_d       = mask_q;
        seg_d        = seg_q;
        wr_en_d      = 4'b0000;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        seg_done_d   = 1'b0;
        frame_done_d = 1'b0;

        if (!enable) begin
            // Dropping enable abandons any partial segment silently; the
            // next run starts from the lowest enabled channel at address 0.
            state_d = ST_IDLE;
            count_d = '0;
            mask_d  = ch_en;
            seg_d   = (|ch_en) ? first_seg : 2'd0;
        end else if (state_q == ST_IDLE) begin
            // First enabled cycle only arms the receiver; seg_idx is kept.
            state_d = ST_RUN;
        end else if (in_valid) begin
            wr_data_d = in_data;
            wr_addr_d = count_q;
            // Disabled segments are still counted so the receiver stays in
            // step with the transmitter, but their (zero) bytes are dropped.
            if (mask_q[seg_q]) begin
                wr_en_d = 4'b0001 << seg_q;
            end
            if (count_q == last_addr(seg_q)) begin
                count_d      = '0;
                mask_d       = ch_en;
                seg_d        = bnd_seg;
                seg_done_d   = 1'b1;
                frame_done_d = (bnd_seg <= seg_q);
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            mask_q       <= 4'b0000;
            seg_q        <= 2'd0;
            wr_en_q      <= 4'b0000;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            seg_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            mask_q       <= mask_d;
            seg_q        <= seg_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            seg_done_q   <= seg_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign seg_idx    = seg_q;
    assign seg_done   = seg_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_demux.sv
module tb_seg_demux;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] ch_en;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] seg_idx;
    logic       seg_done;
    logic       frame_done;

    int         checks;
    int         failures;
    logic [7:0] dval;

    seg_demux dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ch_en      (ch_en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .seg_idx    (seg_idx),
        .seg_done   (seg_done),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stream input, then sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_seg_done"}, 32'(seg_done), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // Send n bytes of segment sidx starting at address start. The byte at
    // address len-1 is the boundary and must raise seg_done (and frame_done
    // when fd). With gap set, an idle cycle follows every byte.
    task automatic run_seg(input logic [1:0] sidx, input int len, input int start, input int n,
                           input logic [3:0] en, input logic fd, input logic gap);
        logic last;
        chk("seg_idx_start", 32'(seg_idx), 32'(sidx));
        for (int a = start; a < start + n; a++) begin
            last = (a == len - 1);
            cyc(1'b1, dval);
            chk("wr_en", 32'(wr_en), 32'(en));
            chk("wr_addr", 32'(wr_addr), 32'(a));
            chk("wr_data", 32'(wr_data), 32'(dval));
            chk("seg_done", 32'(seg_done), 32'(last));
            chk("frame_done", 32'(frame_done), 32'(last && fd));
            dval = dval + 8'd1;
            if (gap) begin
                cyc(1'b0, 8'hEE);
                chk_quiet("gap");
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_seg_idx"}, 32'(seg_idx), 32'd0);
        chk({tag, "_seg_done"}, 32'(seg_done), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        dval     = 8'd0;
        rst      = 1'b1;
        enable   = 1'b0;
        ch_en    = 4'b0000;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");

        // IDLE with all channels enabled, then arm.
        rst   = 1'b0;
        ch_en = 4'b1111;
        cyc(1'b0, 8'd0);
        chk("idle_seg_idx_1111", 32'(seg_idx), 32'd0);
        chk_quiet("idle");
        enable = 1'b1;
        cyc(1'b0, 8'd0);
        chk_quiet("arm");

        // Full frame of continuous ramp data over all four channels.
        run_seg(2'd0, 132, 0, 132, 4'b0001, 1'b0, 1'b0);
        run_seg(2'd1, 121, 0, 121, 4'b0010, 1'b0, 1'b0);
        run_seg(2'd2,  88, 0,  88, 4'b0100, 1'b0, 1'b0);
        run_seg(2'd3,  55, 0,  55, 4'b1000, 1'b1, 1'b0);

        // Second frame: segment 1 paced by in_valid toggling every cycle,
        // ch_en narrowed to channel 0 part way through it.
        run_seg(2'd0, 132, 0, 132, 4'b0001, 1'b0, 1'b0);
        run_seg(2'd1, 121, 0, 10, 4'b0010, 1'b0, 1'b1);
        ch_en = 4'b0001;
        run_seg(2'd1, 121, 10, 111, 4'b0010, 1'b1, 1'b1);

        // Only channel 0 enabled: segment 0 repeats, each one ends a frame.
        run_seg(2'd0, 132, 0, 132, 4'b0001, 1'b1, 1'b0);

        // Channels 0 and 2: 0 -> 2 -> 0 -> 2, frame ends after each seg 2.
        ch_en = 4'b0101;
        run_seg(2'd0, 132, 0, 132, 4'b0001, 1'b0, 1'b0);
        run_seg(2'd2,  88, 0,  88, 4'b0100, 1'b1, 1'b0);
        run_seg(2'd0, 132, 0, 132, 4'b0001, 1'b0, 1'b0);
        run_seg(2'd2,  88, 0,  88, 4'b0100, 1'b1, 1'b0);

        // Drop enable at seg 0 count 70, then restart at ch0 address 0.
        ch_en = 4'b1111;
        run_seg(2'd0, 132, 0, 70, 4'b0001, 1'b0, 1'b0);
        enable = 1'b0;
        cyc(1'b1, 8'h55);
        chk_quiet("drop_enable");
        chk("drop_seg_idx", 32'(seg_idx), 32'd0);
        enable = 1'b1;
        cyc(1'b0, 8'd0);
        chk_quiet("rearm");
        run_seg(2'd0, 132, 0, 5, 4'b0001, 1'b0, 1'b0);

        // Only channel 3: IDLE picks segment 3, 55-byte segments repeat.
        enable = 1'b0;
        ch_en  = 4'b1000;
        cyc(1'b0, 8'd0);
        chk("idle_seg_idx_1000", 32'(seg_idx), 32'd3);
        enable = 1'b1;
        cyc(1'b0, 8'd0);
        run_seg(2'd3, 55, 0, 55, 4'b1000, 1'b1, 1'b0);
        run_seg(2'd3, 55, 0, 55, 4'b1000, 1'b1, 1'b0);

        // Reset in the middle of segment 2 (count 40) with a byte pending.
        enable = 1'b0;
        ch_en  = 4'b0100;
        cyc(1'b0, 8'd0);
        chk("idle_seg_idx_0100", 32'(seg_idx), 32'd2);
        enable = 1'b1;
        cyc(1'b0, 8'd0);
        run_seg(2'd2, 88, 0, 40, 4'b0100, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 8'hA5);
        chk_all_zero("mid_rst");
        rst      = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
